alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one instance of the team's existing combinational `alu` between two requesters.
- Each requester has a valid/ready request channel (operands plus ALUop) and a valid/ready response channel (result plus flags).
- Ties are broken round-robin, and each requester's results come back in its own issue order.
- Sits between the issue logic of the multi-unit core and the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width; passed to the `alu` instance.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_A  input  DATA_WIDTH  operand A.
- req0_B  input  DATA_WIDTH  operand B.
- req0_ALUop  input  3  ALU operation code.
- req1_valid, req1_ready, req1_A, req1_B, req1_ALUop: same as requester 0, for requester 1.
- resp0_valid  output  1  result for requester 0 available.
- resp0_ready  input  1  requester 0 consumes the result.
- resp0_result  output  DATA_WIDTH  ALU Result.
- resp0_flags  output  3  {Overflow, CarryOut, Zero}.
- resp1_valid, resp1_ready, resp1_result, resp1_flags: same as requester 0, for requester 1.

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high.
- While rst is high:
  - state=IDLE, last_grant=1.
  - All resp*_valid, resp*_result, resp*_flags are 0.
  - Internal operand registers are 0.
- req*_ready is combinational: high only in IDLE, for the granted requester.
- States:
  - IDLE: grant selection.
    - Only one valid: grant it.
    - Both valid: grant the requester opposite last_grant. The first tie after reset goes to requester 0.
    - Neither valid: stay in IDLE.
    - On handshake (valid&ready): latch A, B, ALUop and the owner id; set last_grant to the owner; go to EXEC.
  - EXEC: the `alu` computes from the latched operands. At the clock edge, Result and flags are registered into the owner's resp registers, that resp*_valid is set, and the state goes to RESP.
  - RESP: hold result, flags and valid stable until the owner's resp*_ready is high. On the response handshake, clear resp*_valid and go to IDLE.
- Timing and throughput:
  - Latency: accepted at edge N (leaving IDLE), resp valid visible after edge N+1.
  - A new request is accepted at the earliest one cycle after the response handshake.
  - Throughput: one operation per 3 cycles, unloaded.
- The non-owner's resp*_valid is always 0. Only one operation is ever in flight.
- Requester protocol: a requester holds valid and payload stable until ready. Deasserting valid without a handshake is legal in IDLE (it is simply not granted).
- ALU semantics: the `alu` operation encoding and flag semantics are passed through unchanged:
  - 000 AND, 001 OR, 100 XOR, 101 NOR, 010 ADD, 110 SUB, 111 SLT, 011 SLTU.
  - The block does not modify the result or the flags.
- rst asserted in EXEC or RESP: the operation is discarded with no response, and the reset values above apply immediately.
- resp*_ready high while resp*_valid is low has no effect.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_ops0 and stat_ops1, each 32 bits.
  - Each counts completed response handshakes for its requester.
  - Counters reset to 0, wrap from 0xFFFFFFFF to 0, and increment in the same cycle as the handshake.
- When undefined: no ports and no counter logic.

Decomposition:
- Package alu_share_arb_pkg holds:
  - State encoding constants: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - ALUop constants, shared with issue logic: OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU.
  - Flag bit indices: FLAG_OV=2, FLAG_CO=1, FLAG_Z=0.
- One sub-module: rr_arb2, a 2-way round-robin grant.
  - Inputs: valid[1:0], last_grant. Output: one-hot grant[1:0].
  - Purely combinational.
- The `alu` is instantiated as-is.

Test Plan:
- Single-request ADD overflow:
  - After reset, req0 ADD, A=0x7FFFFFFF, B=0x00000001, resp0_ready=1.
  - Expect req0_ready at cycle 0, resp0_valid visible after edge 1.
  - Expect result 0x80000000, flags 3'b100, resp1_valid=0.
- Tie after reset:
  - Both valid in the same cycle: req0 SUB 5-5, req1 SLT A=0xFFFFFFFF, B=1.
  - Expect req0 granted first: result 0, Zero flag=1.
  - Then req1 granted: result 0x00000001.
- Alternation:
  - Both requesters continuously valid with 4 ops each (ADD i+i), ready always high.
  - Expect grant order 0,1,0,1,...; each requester's results arrive in its issue order.
  - Expect accepts spaced exactly 3 cycles apart.
- Back-pressure:
  - req1 XOR 0xF0F0F0F0^0xFFFF0000, resp1_ready low for 5 cycles while req0 is valid.
  - Expect resp1_result 0x0F0FF0F0 stable throughout and req0_ready=0 throughout.
  - Expect req0 accepted one cycle after the resp1 handshake.
- Reset mid-operation:
  - Assert rst asynchronously during EXEC of a req1 op.
  - Expect all resp outputs 0 immediately and no resp1 ever issued.
  - After release with both valid, expect req0 granted first.
- Stats (macro defined):
  - 3 completed req0 ops and 1 completed req1 op.
  - Expect stat_ops0=3 and stat_ops1=1.
  - Preload stat_ops0 to 0xFFFFFFFF via force, complete one op, expect 0.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: shared definitions for the ALU sharing arbiter.
//   state_t  : arbiter FSM encoding (IDLE / EXEC / RESP)
//   OP_*     : ALUop encodings, also used by the issue logic
//   FLAG_*   : bit positions inside the 3-bit {Overflow, CarryOut, Zero} flags
package alu_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  localparam logic [2:0] OP_SLTU = 3'b011;

  localparam int FLAG_OV = 2;
  localparam int FLAG_CO = 1;
  localparam int FLAG_Z  = 0;

endpackage

// File: rtl/alu.sv
// alu: combinational ALU shared by the core's execution units.
//   ALUop    in  3   operation (see OP_* in alu_share_arb_pkg)
//   A, B     in  DATA_WIDTH operands
//   Result   out DATA_WIDTH result
//   Overflow out 1   signed overflow (ADD/SUB only)
//   CarryOut out 1   carry out of the adder (ADD/SUB only; SUB carry = no borrow)
//   Zero     out 1   Result == 0
module alu
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            ALUop,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  logic                  is_sub;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum;
  logic                  sum_ov;

  // SUB reuses the adder as A + ~B + 1.
  assign is_sub = (ALUop == OP_SUB);
  assign b_eff  = is_sub ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, is_sub};
  assign sum_ov = (A[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                  (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

  // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    Result   = '0;
    Overflow = 1'b0;
    CarryOut = 1'b0;
    case (ALUop)
      OP_AND:  Result = A & B;
      OP_OR:   Result = A | B;
      OP_XOR:  Result = A ^ B;
      OP_NOR:  Result = ~(A | B);
      OP_ADD, OP_SUB: begin
        Result   = sum[DATA_WIDTH-1:0];
        CarryOut = sum[DATA_WIDTH];
        Overflow = sum_ov;
      end
      OP_SLT:  Result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: Result = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: 2-way round-robin grant, purely combinational.
//   valid[1:0]  in  requesters asking this cycle
//   last_grant  in  requester granted most recently
//   grant[1:0]  out one-hot grant (all zero when nobody is valid)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the requester that did not win last time goes first.
  assign grant[0] = valid[0] & (~valid[1] |  last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational alu between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (alu evaluates latched
// operands) -> RESP (hold result until the owner takes it) -> IDLE.
//   clk, rst                 clock, asynchronous active-high reset
//   req{0,1}_valid/ready     request handshake (ready only in IDLE, to the grantee)
//   req{0,1}_A/_B/_ALUop     operands and operation
//   resp{0,1}_valid/ready    response handshake (only the owner ever sees valid)
//   resp{0,1}_result/_flags  alu Result and {Overflow, CarryOut, Zero}
// Optional (`define ALU_SHARE_ARB_STATS_EN):
//   stat_ops0/stat_ops1      32-bit wrapping counts of completed response handshakes
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [2:0]            req0_ALUop,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [2:0]            req1_ALUop,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_result,
  output logic [2:0]            resp0_flags,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_result,
  output logic [2:0]            resp1_flags
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [31:0]           stat_ops0,
  output logic [31:0]           stat_ops1
`endif
);

  state_t                state, state_nxt;
  logic                  last_grant;
  logic                  owner;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [2:0]            op_code;

  logic [1:0]            grant;
  logic                  accept;
  logic                  resp_hs;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_ov, alu_co, alu_z;
  logic [2:0]            alu_flags;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req0_ready = (state == IDLE) & grant[0];
  assign req1_ready = (state == IDLE) & grant[1];
  // A grant implies valid, so ready alone marks the handshake.
  assign accept     = req0_ready | req1_ready;
  // resp*_valid is always set while in RESP, so only the owner's ready matters.
  assign resp_hs    = (state == RESP) & (owner ? resp1_ready : resp0_ready);

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .ALUop    (op_code),
    .A        (op_a),
    .B        (op_b),
    .Result   (alu_result),
    .Overflow (alu_ov),
    .CarryOut (alu_co),
    .Zero     (alu_z)
  );

  assign alu_flags[FLAG_OV] = alu_ov;
  assign alu_flags[FLAG_CO] = alu_co;
  assign alu_flags[FLAG_Z]  = alu_z;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand registers are reset even though nothing reads them before a grant, so the alu inputs are never X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;  // first tie after reset goes to requester 0
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
    end else if (accept) begin
      last_grant <= grant[1];
      owner      <= grant[1];
      op_a       <= grant[1] ? req1_A     : req0_A;
      op_b       <= grant[1] ? req1_B     : req0_B;
      op_code    <= grant[1] ? req1_ALUop : req0_ALUop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp0_flags  <= '0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      resp1_flags  <= '0;
    end else if (state == EXEC) begin
      if (owner) begin
        resp1_valid  <= 1'b1;
        resp1_result <= alu_result;
        resp1_flags  <= alu_flags;
      end else begin
        resp0_valid  <= 1'b1;
        resp0_result <= alu_result;
        resp0_flags  <= alu_flags;
      end
    end else if (resp_hs) begin
      // Result and flags stay as they were; only valid drops.
      if (owner) resp1_valid <= 1'b0;
      else       resp0_valid <= 1'b0;
    end
  end

`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops0 <= '0;
      stat_ops1 <= '0;
    end else if (resp_hs) begin
      if (owner) stat_ops1 <= stat_ops1 + 32'd1;
      else       stat_ops0 <= stat_ops0 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed scenarios plus randomized traffic for alu_share_arb,
// checked cycle by cycle against a transaction-level reference model.
// Define ALU_SHARE_ARB_STATS_EN to also exercise the statistics counters.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int DW = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [2:0]    req0_ALUop = '0, req1_ALUop = '0;
  logic          resp0_valid, resp1_valid;
  logic          resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [DW-1:0] resp0_result, resp1_result;
  logic [2:0]    resp0_flags, resp1_flags;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [31:0]   stat_ops0, stat_ops1;
`endif

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_A       (req0_A),
    .req0_B       (req0_B),
    .req0_ALUop   (req0_ALUop),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_A       (req1_A),
    .req1_B       (req1_B),
    .req1_ALUop   (req1_ALUop),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_result (resp0_result),
    .resp0_flags  (resp0_flags),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_result (resp1_result),
    .resp1_flags  (resp1_flags)
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    .stat_ops0    (stat_ops0),
    .stat_ops1    (stat_ops1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus wanted by the scenario for the coming cycle.
  logic [1:0]    s_v  = '0;
  logic [1:0]    s_rr = '0;
  logic [DW-1:0] s_a [2];
  logic [DW-1:0] s_b [2];
  logic [2:0]    s_op[2];

  // Reference model: one op outstanding from accept to response handshake;
  // response appears one edge after accept; ties go opposite the last winner.
  logic          m_busy, m_last, m_pend, m_pown;
  logic [1:0]    m_vld;
  logic [34:0]   m_out[2];
  logic [34:0]   m_q0[$];
  logic [34:0]   m_q1[$];
  logic [31:0]   m_cnt[2];
  int            cyc = 0;
  int            acc_own[$];
  int            acc_cyc[$];
  int            hs_cyc[$];

  // {Overflow, CarryOut, Zero, Result} from plain arithmetic.
  function automatic logic [34:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, sd;
    logic [32:0] w;
    logic [31:0] r;
    logic ov, co;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; ov = 1'b0; co = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        co = w[32];
        sd = sa + sb;
        ov = (sd > SMAX) || (sd < SMIN);
      end
      OP_SUB: begin
        r = a - b;
        co = (a >= b);
        sd = sa - sb;
        ov = (sd > SMAX) || (sd < SMIN);
      end
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
    return {ov, co, (r == 32'd0), r};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_last = 1'b1; m_pend = 1'b0; m_pown = 1'b0;
    m_vld = '0;
    m_out[0] = '0; m_out[1] = '0;
    m_q0.delete(); m_q1.delete();
    m_cnt[0] = '0; m_cnt[1] = '0;
    s_v = '0;
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive, check ready, advance model.
  task automatic cycle();
    int g;
    @(negedge clk);
    cyc++;
    check("resp0_valid", resp0_valid, m_vld[0]);
    check("resp1_valid", resp1_valid, m_vld[1]);
    if (m_vld[0]) begin
      check("resp0_result", resp0_result, m_out[0][31:0]);
      check("resp0_flags",  resp0_flags,  m_out[0][34:32]);
    end
    if (m_vld[1]) begin
      check("resp1_result", resp1_result, m_out[1][31:0]);
      check("resp1_flags",  resp1_flags,  m_out[1][34:32]);
    end
    req0_valid = s_v[0]; req0_A = s_a[0]; req0_B = s_b[0]; req0_ALUop = s_op[0];
    req1_valid = s_v[1]; req1_A = s_a[1]; req1_B = s_b[1]; req1_ALUop = s_op[1];
    resp0_ready = s_rr[0]; resp1_ready = s_rr[1];
    #1;
    g = -1;
    if (!m_busy) begin
      if (s_v[0] && s_v[1]) g = m_last ? 0 : 1;
      else if (s_v[0])      g = 0;
      else if (s_v[1])      g = 1;
    end
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    for (int i = 0; i < 2; i++) begin
      if (m_vld[i] && s_rr[i]) begin
        m_vld[i] = 1'b0;
        m_busy = 1'b0;
        m_cnt[i] = m_cnt[i] + 32'd1;
        hs_cyc.push_back(cyc);
      end
    end
    if (m_pend) begin
      m_vld[m_pown] = 1'b1;
      m_out[m_pown] = m_pown ? m_q1.pop_front() : m_q0.pop_front();
      m_pend = 1'b0;
    end
    if (g >= 0) begin
      if (g == 1) m_q1.push_back(alu_ref(s_op[1], s_a[1], s_b[1]));
      else        m_q0.push_back(alu_ref(s_op[0], s_a[0], s_b[0]));
      m_pend = 1'b1; m_pown = g[0]; m_busy = 1'b1; m_last = g[0];
      acc_own.push_back(g);
      acc_cyc.push_back(cyc);
      s_v[g] = 1'b0;
    end
  endtask

  task automatic run_until_accepts(input int n, input int maxc, input string tag);
    int start;
    int k;
    start = acc_own.size();
    k = 0;
    while ((acc_own.size() - start) < n && k < maxc) begin
      cycle();
      k++;
    end
    check(tag, acc_own.size() - start, n);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    s_v[i] = 1'b1; s_op[i] = op; s_a[i] = a; s_b[i] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    @(negedge clk);
    check("rst_resp0_valid",  resp0_valid,  0);
    check("rst_resp1_valid",  resp1_valid,  0);
    check("rst_resp0_result", resp0_result, 0);
    check("rst_resp1_result", resp1_result, 0);
    check("rst_resp0_flags",  resp0_flags,  0);
    check("rst_resp1_flags",  resp1_flags,  0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int start;
    int issued[2];
    int k;
    for (int i = 0; i < 2; i++) begin
      s_a[i] = '0; s_b[i] = '0; s_op[i] = '0;
    end

    // Single-request ADD with signed overflow.
    do_reset();
    s_rr = 2'b11;
    set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    cycle();
    check("add_ready0", req0_ready, 1);
    @(posedge clk); #1;
    check("add_not_early", resp0_valid, 0);
    cycle();
    @(posedge clk); #1;
    check("add_valid0", resp0_valid, 1);
    check("add_result", resp0_result, 32'h8000_0000);
    check("add_flags", resp0_flags, 3'b100);
    check("add_valid1", resp1_valid, 0);
    cycle();
    cycle();

    // First tie after reset goes to requester 0.
    do_reset();
    s_rr = 2'b11;
    set_req(0, OP_SUB, 32'd5, 32'd5);
    set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    run_until_accepts(1, 10, "tie_acc0");
    check("tie_first_owner", acc_own[$], 0);
    cycle();
    @(posedge clk); #1;
    check("tie_sub_result", resp0_result, 0);
    check("tie_sub_zero", resp0_flags[FLAG_Z], 1);
    run_until_accepts(1, 10, "tie_acc1");
    check("tie_second_owner", acc_own[$], 1);
    cycle();
    @(posedge clk); #1;
    check("tie_slt_result", resp1_result, 32'd1);
    cycle();
    cycle();

    // Alternation under continuous load.
    s_rr = 2'b11;
    issued[0] = 0; issued[1] = 0;
    start = acc_own.size();
    k = 0;
    while ((acc_own.size() - start) < 8 && k < 60) begin
      for (int i = 0; i < 2; i++) begin
        if (!s_v[i] && issued[i] < 4) begin
          set_req(i, OP_ADD, 32'(issued[i] + 1 + 16 * i), 32'(issued[i] + 1 + 16 * i));
          issued[i]++;
        end
      end
      cycle();
      k++;
    end
    check("alt_accepts", acc_own.size() - start, 8);
    for (int j = 0; j < 8 && (start + j) < acc_own.size(); j++)
      check("alt_order", acc_own[start + j], j % 2);
    for (int j = 1; j < 8 && (start + j) < acc_cyc.size(); j++)
      check("alt_gap", acc_cyc[start + j] - acc_cyc[start + j - 1], 3);
    repeat (3) cycle();

    // Back-pressure on requester 1 while requester 0 waits.
    s_rr = 2'b01;
    set_req(1, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
    run_until_accepts(1, 10, "bp_acc1");
    set_req(0, OP_ADD, 32'd3, 32'd4);
    cycle();
    for (int j = 0; j < 5; j++) begin
      cycle();
      check("bp_result_hold", resp1_result, 32'h0F0F_F0F0);
      check("bp_ready0_low", req0_ready, 0);
    end
    s_rr = 2'b11;
    cycle();
    run_until_accepts(1, 10, "bp_acc0");
    check("bp_owner", acc_own[$], 0);
    check("bp_gap", acc_cyc[$] - hs_cyc[$], 1);
    repeat (3) cycle();

    // Asynchronous reset in the middle of a requester-1 operation.
    s_rr = 2'b11;
    set_req(1, OP_OR, 32'h1234_0000, 32'h0000_5678);
    run_until_accepts(1, 10, "mid_acc1");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_resp0_valid",  resp0_valid,  0);
    check("mid_resp1_valid",  resp1_valid,  0);
    check("mid_resp0_result", resp0_result, 0);
    check("mid_resp1_result", resp1_result, 0);
    check("mid_resp0_flags",  resp0_flags,  0);
    check("mid_resp1_flags",  resp1_flags,  0);
    model_reset();
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    s_rr = 2'b11;
    repeat (4) cycle();
    set_req(0, OP_NOR, 32'h0, 32'h0);
    set_req(1, OP_SLTU, 32'h1, 32'hFFFF_FFFF);
    run_until_accepts(1, 10, "mid_acc_after");
    check("mid_first_owner", acc_own[$], 0);
    repeat (8) cycle();

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!s_v[i] && $urandom_range(0, 2) != 0)
          set_req(i, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        s_rr[i] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    s_rr = 2'b11;
    repeat (12) cycle();
    check("drain_resp0", resp0_valid, 0);
    check("drain_resp1", resp1_valid, 0);

`ifdef ALU_SHARE_ARB_STATS_EN
    // Statistics counters and their wrap.
    do_reset();
    s_rr = 2'b11;
    for (int j = 0; j < 3; j++) begin
      set_req(0, OP_AND, $urandom, $urandom);
      run_until_accepts(1, 10, "stat_acc0");
      cycle();
      cycle();
    end
    set_req(1, OP_OR, $urandom, $urandom);
    run_until_accepts(1, 10, "stat_acc1");
    cycle();
    cycle();
    cycle();
    check("stat_ops0", stat_ops0, m_cnt[0]);
    check("stat_ops1", stat_ops1, m_cnt[1]);
    check("stat_ops0_three", stat_ops0, 32'd3);
    check("stat_ops1_one", stat_ops1, 32'd1);
    force dut.stat_ops0 = 32'hFFFF_FFFF;
    #1;
    release dut.stat_ops0;
    m_cnt[0] = 32'hFFFF_FFFF;
    set_req(0, OP_ADD, 32'd1, 32'd1);
    run_until_accepts(1, 10, "stat_acc_wrap");
    cycle();
    cycle();
    cycle();
    check("stat_wrap_model", stat_ops0, m_cnt[0]);
    check("stat_wrap_zero", stat_ops0, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
